// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-requester single-port RAM arbiter.
package ram_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin winner select; i_ptr names the requester that wins a tie.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) o_grant = i_ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two requesters onto one external single-port RAM (IDLE/ACCESS/RESP).
// Optional per-requester ack counters gcnt0/gcnt1 under macro RAM_ARB_STATS_EN.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [7:0]        gcnt0,
  output logic [7:0]        gcnt1
`endif
);

  state_t            r_state, w_next;
  logic              r_ptr;
  logic              r_win;
  logic [1:0]        r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ram_en, r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;
  logic [1:0]        w_grant;
  logic              w_win;

  rr_arb2 u_rr (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign w_win = w_grant[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (|req) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Payload is latched only in IDLE, so requesters may drop req once granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= 1'b0;
      r_win      <= 1'b0;
      r_ack      <= '0;
      r_rdata    <= '0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_win      <= w_win;
            r_ptr      <= ~w_win;
            r_ram_en   <= 1'b1;
            r_ram_we   <= we[w_win];
            r_ram_addr <= w_win ? addr1 : addr0;
            r_ram_din  <= w_win ? wdata1 : wdata0;
          end
        end
        ST_ACCESS: begin
          if (!r_ram_we) r_rdata <= ram_dout;
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          r_ack    <= r_win ? 2'b10 : 2'b01;
        end
        default: ;
      endcase
    end
  end

  assign ack      = r_ack;
  assign rdata    = r_rdata;
  assign ram_en   = r_ram_en;
  assign ram_we   = r_ram_we;
  assign ram_addr = r_ram_addr;
  assign ram_din  = r_ram_din;

`ifdef RAM_ARB_STATS_EN
  logic [7:0] r_gcnt0, r_gcnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
    end else if (r_state == ST_ACCESS) begin
      if (r_win) r_gcnt1 <= r_gcnt1 + 8'd1;
      else       r_gcnt0 <= r_gcnt0 + 8'd1;
    end
  end

  assign gcnt0 = r_gcnt0;
  assign gcnt1 = r_gcnt1;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: vector table, corner sequences, random vs schedule model.
// Counter checks compile in when RAM_ARB_STATS_EN is defined.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = '0, we = '0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic [1:0] ack;
  logic [7:0] rdata;
  logic       ram_en, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
`ifdef RAM_ARB_STATS_EN
  logic [7:0] gcnt0, gcnt1;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
`ifdef RAM_ARB_STATS_EN
    , .gcnt0(gcnt0), .gcnt1(gcnt1)
`endif
  );

  // External RAM: combinational read, synchronous write.
  logic [7:0] tb_mem [16];
  assign ram_dout = tb_mem[ram_addr];
  always @(posedge clk) if (ram_en && ram_we) tb_mem[ram_addr] <= ram_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ack"}, 32'(ack), 0);
    chk({tag, " rdata"}, 32'(rdata), 0);
    chk({tag, " ram_en"}, 32'(ram_en), 0);
    chk({tag, " ram_we"}, 32'(ram_we), 0);
    chk({tag, " ram_addr"}, 32'(ram_addr), 0);
    chk({tag, " ram_din"}, 32'(ram_din), 0);
`ifdef RAM_ARB_STATS_EN
    chk({tag, " gcnt0"}, 32'(gcnt0), 0);
    chk({tag, " gcnt1"}, 32'(gcnt1), 0);
`endif
  endtask

  // Leaves the bench just after a rising edge with the DUT idle.
  task automatic do_reset();
    rst = 1'b1; req = '0; we = '0;
    @(negedge clk);
    chk_zero("reset");
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] req, we;
    logic [3:0] a0, a1;
    logic [7:0] w0, w1;
    logic [1:0] eack;
    logic       ewe;
    logic [3:0] eaddr;
    logic [7:0] edin, erd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           req    we     a0    a1    w0     w1     ack    we    addr  din    rdata
    tbl[0] = '{2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00, 2'b01, 1'b1, 4'd3, 8'hA5, 8'h00};
    tbl[1] = '{2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00, 2'b10, 1'b0, 4'd3, 8'h00, 8'hA5};
    tbl[2] = '{2'b11, 2'b11, 4'd5, 4'd6, 8'h11, 8'h22, 2'b01, 1'b1, 4'd5, 8'h11, 8'hA5};
    tbl[3] = '{2'b11, 2'b11, 4'd5, 4'd6, 8'h11, 8'h22, 2'b10, 1'b1, 4'd6, 8'h22, 8'hA5};
    tbl[4] = '{2'b11, 2'b00, 4'd6, 4'd5, 8'h00, 8'h00, 2'b01, 1'b0, 4'd6, 8'h00, 8'h22};
    tbl[5] = '{2'b10, 2'b00, 4'd0, 4'd5, 8'h00, 8'h00, 2'b10, 1'b0, 4'd5, 8'h00, 8'h11};
    tbl[6] = '{2'b10, 2'b10, 4'd0, 4'd7, 8'h00, 8'h3C, 2'b10, 1'b1, 4'd7, 8'h3C, 8'h11};
    tbl[7] = '{2'b11, 2'b00, 4'd7, 4'd3, 8'h00, 8'h00, 2'b01, 1'b0, 4'd7, 8'h00, 8'h3C};
    tbl[8] = '{2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00, 2'b01, 1'b0, 4'd3, 8'h00, 8'hA5};

    do_reset();

    // Vector table: one full transaction per entry.
    for (int v = 0; v < 9; v++) begin
      req = tbl[v].req; we = tbl[v].we; addr0 = tbl[v].a0; addr1 = tbl[v].a1;
      wdata0 = tbl[v].w0; wdata1 = tbl[v].w1;
      @(negedge clk);
      chk($sformatf("v%0d idle ack", v), 32'(ack), 0);
      step();
      @(negedge clk);
      chk($sformatf("v%0d ram_en", v), 32'(ram_en), 1);
      chk($sformatf("v%0d ram_we", v), 32'(ram_we), 32'(tbl[v].ewe));
      chk($sformatf("v%0d ram_addr", v), 32'(ram_addr), 32'(tbl[v].eaddr));
      chk($sformatf("v%0d ram_din", v), 32'(ram_din), 32'(tbl[v].edin));
      chk($sformatf("v%0d access ack", v), 32'(ack), 0);
      step();
      @(negedge clk);
      chk($sformatf("v%0d ack", v), 32'(ack), 32'(tbl[v].eack));
      chk($sformatf("v%0d resp ram_en", v), 32'({ram_en, ram_we}), 0);
      chk($sformatf("v%0d rdata", v), 32'(rdata), 32'(tbl[v].erd));
      step();
    end
    req = '0;

    // Request withdrawn during ACCESS still completes.
    req = 2'b01; we = 2'b00; addr0 = 4'd3;
    @(negedge clk);
    step();
    req = 2'b00;
    @(negedge clk);
    chk("drop ram_en", 32'(ram_en), 1);
    chk("drop ram_addr", 32'(ram_addr), 3);
    step();
    @(negedge clk);
    chk("drop ack", 32'(ack), 32'(2'b01));
    chk("drop rdata", 32'(rdata), 32'hA5);
    step();

    // Reset mid-ACCESS: requester 1 would win, but the abort resets the pointer.
    req = 2'b11; we = 2'b00; addr0 = 4'd3; addr1 = 4'd5;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("abort pre ram_addr", 32'(ram_addr), 5);
    #1 rst = 1'b1;
    #1 chk_zero("abort");
    @(negedge clk);
    chk("abort no ack", 32'(ack), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort regrant en", 32'(ram_en), 1);
    chk("abort regrant addr", 32'(ram_addr), 3);
    chk("abort regrant ack", 32'(ack), 0);
    @(negedge clk);
    chk("abort regrant ack0", 32'(ack), 32'(2'b01));
    step();
    req = '0;

    // Both requesters held high: alternating grants every 3 cycles.
    do_reset();
    begin
      int n;
      int acyc [8];
      logic [1:0] aval [8];
      n = 0;
      req = 2'b11; we = 2'b11; addr0 = 4'd8; addr1 = 4'd9; wdata0 = 8'h01; wdata1 = 8'h02;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (ack != 2'b00 && n < 8) begin
          acyc[n] = i; aval[n] = ack; n++;
        end
      end
      step();
      req = '0;
      chk("rr ack count", 32'(n), 4);
      if (n >= 1) chk("rr first latency", 32'(acyc[0]), 2);
      for (int k = 0; k < 4 && k < n; k++) begin
        chk($sformatf("rr order %0d", k), 32'(aval[k]), (k % 2) ? 32'd2 : 32'd1);
        if (k > 0) chk($sformatf("rr spacing %0d", k), 32'(acyc[k] - acyc[k-1]), 3);
      end
    end

    // Random traffic against a grant-schedule model.
    do_reset();
    begin
      logic [7:0] m_mem [16];
      int         next_free, g_cyc;
      logic       m_prio, g_win, g_we;
      logic [3:0] g_addr;
      logic [7:0] g_din, g_rv, m_rd, erd;
      logic [1:0] pend, done;
      logic       w;
      for (int a = 0; a < 16; a++) m_mem[a] = tb_mem[a];
      next_free = 0; g_cyc = -10; m_prio = 1'b0; m_rd = 8'h00;
      g_win = 0; g_we = 0; g_addr = 0; g_din = 0; g_rv = 0;
      pend = '0; done = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(negedge clk);
        chk("rnd ram_en", 32'(ram_en), 32'(cyc == g_cyc + 1));
        if (cyc == g_cyc + 1) begin
          chk("rnd ram_we", 32'(ram_we), 32'(g_we));
          chk("rnd ram_addr", 32'(ram_addr), 32'(g_addr));
          chk("rnd ram_din", 32'(ram_din), 32'(g_din));
        end
        if (cyc == g_cyc + 2) begin
          chk("rnd ack", 32'(ack), g_win ? 32'd2 : 32'd1);
          erd = g_we ? m_rd : g_rv;
          chk("rnd rdata", 32'(rdata), 32'(erd));
          m_rd = erd;
          done[g_win] = 1'b1;
        end else begin
          chk("rnd no ack", 32'(ack), 0);
        end
        @(posedge clk);
        if (cyc >= next_free && req != 2'b00) begin
          w = (req == 2'b11) ? m_prio : req[1];
          g_cyc = cyc; next_free = cyc + 3; m_prio = ~w; g_win = w;
          g_we = we[w]; g_addr = w ? addr1 : addr0; g_din = w ? wdata1 : wdata0;
          if (g_we) m_mem[g_addr] = g_din;
          else      g_rv = m_mem[g_addr];
        end
        #1;
        for (int i = 0; i < 2; i++) begin
          if (done[i]) begin pend[i] = 1'b0; done[i] = 1'b0; end
          if (!pend[i] && $urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1;
            we[i] = 1'($urandom_range(0, 1));
            if (i == 0) begin addr0 = 4'($urandom_range(0, 15)); wdata0 = 8'($urandom); end
            else        begin addr1 = 4'($urandom_range(0, 15)); wdata1 = 8'($urandom); end
          end
        end
        req = pend;
      end
      req = '0;
    end

`ifdef RAM_ARB_STATS_EN
    do_reset();
    begin
      int n;
      n = 0;
      req = 2'b10; we = 2'b00; addr1 = 4'd0;
      for (int i = 0; i < 2000 && n < 257; i++) begin
        @(negedge clk);
        if (ack == 2'b10) n++;
      end
      step();
      req = '0;
      chk("stats ack count", 32'(n), 257);
      @(negedge clk);
      chk("stats gcnt1 wrap", 32'(gcnt1), 1);
      chk("stats gcnt0", 32'(gcnt0), 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
